// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin arbiter that time-shares one external MAC
// (latency 3, CLEAR loads the product) among N requesters. It computes one
// dot product per job and returns the result through a valid/ready port.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both high. A producer holding valid keeps its payload stable
// until that edge. Operands use in_valid[i]/in_ready[i]; results use
// res_valid/res_ready. res_id, res_data and res_valid hold until accepted.
//
// Every output except res_data is a flop. A state's drive is therefore
// visible in the cycle after the edge that decided it. As a result, DRAIN
// is entered on the last accepting edge, and its two MAC-enable cycles
// appear on the outputs during the two cycles that follow.
module mac_scheduler #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 42,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [8*N-1:0]  len,
    input  logic [DW*N-1:0] a_in,
    input  logic [DW*N-1:0] b_in,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic            mac_en,
    output logic            mac_clear,
    output logic [DW-1:0]   mac_a,
    output logic [DW-1:0]   mac_b,
    input  logic [AW-1:0]   mac_acc,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IW-1:0]   res_id,
    output logic [AW-1:0]   res_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      drain_q, drain_d;
    logic            zero_job_q, zero_job_d;
    logic [N-1:0]    in_ready_q, in_ready_d;
    logic            res_valid_q, res_valid_d;
    logic            mac_en_q, mac_en_d;
    logic            mac_clear_q, mac_clear_d;
    logic [DW-1:0]   mac_a_q, mac_a_d;
    logic [DW-1:0]   mac_b_q, mac_b_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [7:0]      win_len;
    logic [DW-1:0]   gnt_a;
    logic [DW-1:0]   gnt_b;

    // Round-robin pick: first set req at or after ptr, wrapping. The loop
    // runs from the farthest offset down, so the nearest hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % N]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + i) % N);
            end
        end
    end

    assign win_len = len[8*int'(win_idx) +: 8];
    assign gnt_a   = a_in[DW*int'(grant_q) +: DW];
    assign gnt_b   = b_in[DW*int'(grant_q) +: DW];

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        zero_job_d  = zero_job_q;
        in_ready_d  = in_ready_q;
        res_valid_d = res_valid_q;
        mac_en_d    = 1'b0;
        mac_clear_d = 1'b0;
        mac_a_d     = '0;
        mac_b_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    len_d   = win_len;
                    cnt_d   = '0;
                    if (win_len == 8'd0) begin
                        // Empty job: report zero without touching the MAC.
                        state_d     = S_RESULT;
                        zero_job_d  = 1'b1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d    = S_STREAM;
                        zero_job_d = 1'b0;
                        in_ready_d = N'(1) << win_idx;
                    end
                end
            end
            S_STREAM: begin
                if (in_valid[grant_q] && in_ready_q[grant_q]) begin
                    mac_en_d    = 1'b1;
                    mac_clear_d = (cnt_q == 8'd0);
                    mac_a_d     = gnt_a;
                    mac_b_d     = gnt_b;
                    cnt_d       = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == len_q) begin
                        state_d    = S_DRAIN;
                        in_ready_d = '0;
                        drain_d    = '0;
                    end
                end
            end
            S_DRAIN: begin
                // Two enable cycles with zero operands push the last product
                // through the remaining MAC stages.
                if (drain_q == 2'd2) begin
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                end else begin
                    mac_en_d = 1'b1;
                    drain_d  = drain_q + 2'd1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                    ptr_d       = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            zero_job_q  <= 1'b0;
            in_ready_q  <= '0;
            res_valid_q <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            zero_job_q  <= zero_job_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            mac_en_q    <= mac_en_d;
            mac_clear_q <= mac_clear_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mac_en    = mac_en_q;
    assign mac_clear = mac_clear_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = grant_q;
    // The MAC holds its accumulator while mac_en is low in RESULT, so the
    // accumulator can be passed straight through.
    assign res_data  = (res_valid_q && !zero_job_q) ? mac_acc : '0;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_scheduler.sv
// Bench for mac_scheduler: behavioural 3-stage MAC, per-requester operand
// feeders, and a result scoreboard checked at each result handshake.
module tb_mac_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 42;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [8*N-1:0]  len;
    logic [DW*N-1:0] a_in;
    logic [DW*N-1:0] b_in;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mac_en;
    logic            mac_clear;
    logic [DW-1:0]   mac_a;
    logic [DW-1:0]   mac_b;
    logic [AW-1:0]   mac_acc;
    logic            res_valid;
    logic            res_ready;
    logic [IW-1:0]   res_id;
    logic [AW-1:0]   res_data;
    logic            busy;

    mac_scheduler #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .len       (len),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // MAC model: three enable-gated stages, never reset, seeded with junk
    logic signed [AW-1:0] s1_p  = 777;
    logic signed [AW-1:0] s2_p  = -5;
    logic signed [AW-1:0] acc_m = 12345;
    logic                 s1_c  = 1'b0;
    logic                 s2_c  = 1'b0;
    always @(posedge clk) begin
        if (mac_en) begin
            s1_p  <= $signed({{(AW-DW){mac_a[DW-1]}}, mac_a}) *
                     $signed({{(AW-DW){mac_b[DW-1]}}, mac_b});
            s1_c  <= mac_clear;
            s2_p  <= s1_p;
            s2_c  <= s1_c;
            acc_m <= s2_c ? s2_p : acc_m + s2_p;
        end
    end
    assign mac_acc = acc_m;

    // Feeder storage and scoreboard
    logic [DW-1:0]    a_mem [N][256];
    logic [DW-1:0]    b_mem [N][256];
    int               gap_mem [N][256];
    int               wr [N];
    int               rd [N];
    int               gap_cnt [N];
    int               pos [N];
    longint           job_sum [N];
    logic [IW+AW-1:0] exp_q [$];

    logic [N-1:0]  pend = '0;
    logic          x_any = 1'b0;
    logic          x_first = 1'b0;
    logic [DW-1:0] x_a = '0;
    logic [DW-1:0] x_b = '0;
    logic          prev_ready_any = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_rr = 1'b0;
    logic [IW-1:0] prev_id = '0;
    logic [AW-1:0] prev_data = '0;
    logic          track = 1'b0;
    int            since = 0;
    int            en_count = 0;
    int            last_id = N - 1;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_mac_en"},    64'(mac_en),    64'd0);
        chk({tag, "_mac_clear"}, 64'(mac_clear), 64'd0);
        chk({tag, "_mac_a"},     64'(mac_a),     64'd0);
        chk({tag, "_mac_b"},     64'(mac_b),     64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_id"},    64'(res_id),    64'd0);
        chk({tag, "_res_data"},  64'(res_data),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Driver tasks
    task automatic new_job(input int id);
        wr[id] = 0; rd[id] = 0; pos[id] = 0; gap_cnt[id] = 0; job_sum[id] = 0;
    endtask

    task automatic push_elem(input int id, input int a, input int b, input int gap);
        a_mem[id][wr[id]]   = DW'(a);
        b_mem[id][wr[id]]   = DW'(b);
        gap_mem[id][wr[id]] = gap;
        job_sum[id] += longint'(a) * longint'(b);
        wr[id]++;
    endtask

    task automatic start_job(input int id, input int ln, input logic [AW-1:0] e);
        len[8*id +: 8] = 8'(ln);
        req[id] = 1'b1;
        exp_q.push_back({IW'(id), e});
        last_id = id;
    endtask

    // Pre-edge work (clock low): result handshake, operand drive, sampling
    task automatic sample_pre();
        logic [IW+AW-1:0] ent;
        if (reset_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res_valid", 64'(res_valid), 64'd0);
            end else begin
                ent = exp_q.pop_front();
                chk("sb_res_id",   64'(res_id),   64'(ent[IW+AW-1:AW]));
                chk("sb_res_data", 64'(res_data), 64'(ent[AW-1:0]));
            end
            req[res_id] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            if (rd[i] < wr[i]) begin
                a_in[DW*i +: DW] = a_mem[i][rd[i]];
                b_in[DW*i +: DW] = b_mem[i][rd[i]];
                if (gap_cnt[i] > 0 && in_ready[i]) gap_cnt[i]--;
                else in_valid[i] = 1'b1;
            end
            pend[i] = in_valid[i] && in_ready[i] && reset_n;
            if (pend[i]) begin
                x_a     = a_mem[i][rd[i]];
                x_b     = b_mem[i][rd[i]];
                x_first = (pos[i] == 0);
            end
        end
        x_any          = |pend;
        prev_ready_any = |in_ready;
        prev_valid     = res_valid;
        prev_rr        = res_ready;
        prev_id        = res_id;
        prev_data      = res_data;
    endtask

    // Post-edge checks (sampled on the falling edge)
    task automatic monitor_post();
        if (reset_n) begin
            if (x_any) begin
                chk("xfer_mac_en",    64'(mac_en),    64'd1);
                chk("xfer_mac_a",     64'(mac_a),     64'(x_a));
                chk("xfer_mac_b",     64'(mac_b),     64'(x_b));
                chk("xfer_mac_clear", 64'(mac_clear), 64'(x_first));
            end else if (prev_ready_any) begin
                chk("stall_mac_en", 64'(mac_en), 64'd0);
                chk("stall_mac_a",  64'(mac_a),  64'd0);
            end
            if (track && (since == 1 || since == 2)) begin
                chk("drain_mac_en",    64'(mac_en),    64'd1);
                chk("drain_mac_a",     64'(mac_a),     64'd0);
                chk("drain_mac_clear", 64'(mac_clear), 64'd0);
                chk("drain_res_valid", 64'(res_valid), 64'd0);
            end
            if (track && since == 3) begin
                chk("res_valid_latency", 64'(res_valid), 64'd1);
                track = 1'b0;
            end
            if (prev_valid && !prev_rr) begin
                chk("hold_res_valid", 64'(res_valid), 64'd1);
                chk("hold_res_id",    64'(res_id),    64'(prev_id));
                chk("hold_res_data",  64'(res_data),  64'(prev_data));
                chk("hold_mac_en",    64'(mac_en),    64'd0);
            end
            chk("in_ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
            if (mac_en) en_count++;
        end
    endtask

    task automatic tick();
        sample_pre();
        @(posedge clk);
        if (track) since++;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                rd[i]++;
                pos[i]++;
                if (rd[i] < wr[i]) gap_cnt[i] = gap_mem[i][rd[i]];
                else begin
                    track = 1'b1;
                    since = 0;
                end
            end
        end
        @(negedge clk);
        monitor_post();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy || req != '0) && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(exp_q.size() == 0 && !busy && req == '0), 64'd1);
    endtask

    // Directed sequence
    initial begin
        int n;
        int va, vb, ln, id;
        reset_n = 1'b0; req = '0; len = '0; a_in = '0; b_in = '0;
        in_valid = '0; res_ready = 1'b1;
        for (int i = 0; i < N; i++) new_job(i);

        @(negedge clk);
        chk_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // All four requesters, len=1, a=b=i+1: served 0,1,2,3
        for (int i = 0; i < N; i++) begin
            new_job(i);
            push_elem(i, i + 1, i + 1, 0);
        end
        for (int i = 0; i < N; i++) start_job(i, 1, AW'((i + 1) * (i + 1)));
        wait_idle(200);

        // ptr back at 0: requesters 0 and 3 with empty jobs, 0 first
        new_job(0); new_job(3);
        start_job(0, 0, '0);
        start_job(3, 0, '0);
        wait_idle(50);

        // Requester 0, len=3, continuous stream
        new_job(0);
        push_elem(0, 1, 4, 0); push_elem(0, 2, 5, 0); push_elem(0, 3, 6, 0);
        start_job(0, 3, AW'(32));
        wait_idle(50);

        // Same job with two idle cycles between elements
        new_job(0);
        push_elem(0, 1, 4, 0); push_elem(0, 2, 5, 2); push_elem(0, 3, 6, 2);
        start_job(0, 3, AW'(32));
        wait_idle(60);

        // Requester 2, len=0: zero result, MAC untouched
        new_job(2);
        en_count = 0;
        start_job(2, 0, '0);
        wait_idle(50);
        chk("len0_mac_en_count", 64'(en_count), 64'd0);

        // Result held five cycles with res_ready low
        res_ready = 1'b0;
        new_job(1);
        push_elem(1, -7, 9, 0); push_elem(1, 300, -2, 1);
        start_job(1, 2, AW'(job_sum[1]));
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        chk("hold_wait_res_valid", 64'(res_valid), 64'd1);
        repeat (5) tick();
        res_ready = 1'b1;
        wait_idle(50);

        // len=255 streams exactly 255 elements
        new_job(3);
        for (int k = 0; k < 255; k++) begin
            va = int'($urandom_range(0, 200)) - 100;
            vb = int'($urandom_range(0, 200)) - 100;
            push_elem(3, va, vb, int'($urandom_range(0, 1)));
        end
        start_job(3, 255, AW'(job_sum[3]));
        wait_idle(1200);

        // Random rounds: all requesters at once, order from ptr
        for (int r = 0; r < 4; r++) begin
            id = int'($urandom_range(0, N - 1));
            new_job(id);
            push_elem(id, int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 0);
            start_job(id, 1, AW'(job_sum[id]));
            wait_idle(50);
            for (int k = 0; k < N; k++) begin
                id = (last_id + 1) % N;
                ln = int'($urandom_range(0, 5));
                new_job(id);
                for (int e = 0; e < ln; e++) begin
                    va = int'($urandom_range(0, 2000)) - 1000;
                    vb = int'($urandom_range(0, 2000)) - 1000;
                    push_elem(id, va, vb, int'($urandom_range(0, 2)));
                end
                start_job(id, ln, AW'(job_sum[id]));
            end
            wait_idle(400);
        end

        // Reset mid-stream abandons the job
        new_job(0);
        for (int k = 0; k < 4; k++) push_elem(0, k + 3, k + 5, 0);
        start_job(0, 4, AW'(job_sum[0]));
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk_zero("midjob_reset");
        req = '0;
        new_job(0);
        exp_q.delete();
        track = 1'b0;
        tick();
        chk_zero("reset_held");
        reset_n = 1'b1;
        tick();
        new_job(1);
        push_elem(1, -3, 7, 0); push_elem(1, 5, 2, 0);
        start_job(1, 2, AW'(-11));
        wait_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_scheduler.md
MAC_SCHEDULER -- requirements
Module: mac_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter DW, default 16, giving the operand width.
REQ-003 The block SHALL have parameter AW, default 42, giving the accumulator width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: clock.
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port req, input, N bits: per-requester job request, level, held until its result handshake.
REQ-008 Port len, input, 8N bits: per-requester job length in elements; slice i is bits [8i+7:8i].
REQ-009 Port a_in and b_in, input, DW*N bits each: per-requester signed operand streams.
REQ-010 Port in_valid, input, N bits: per-requester operand valid.
REQ-011 Port in_ready, output, N bits: per-requester operand ready.
REQ-012 Port mac_en, mac_clear, output, 1 bit each: drive EN and CLEAR of the shared MAC; the MAC latency is 3 and CLEAR loads the product.
REQ-013 Port mac_a and mac_b, output, DW bits each: MAC operands.
REQ-014 Port mac_acc, input, AW bits: MAC accumulator output.
REQ-015 Port res_valid, output, 1 bit; res_ready, input, 1 bit: result handshake.
REQ-016 Port res_id, output, log2(N) bits: index of the requester that owns the result.
REQ-017 Port res_data, output, AW bits: dot-product result.
REQ-018 Port busy, output, 1 bit: high in any state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, STREAM, DRAIN, RESULT.
REQ-020 IDLE, any req high: the block SHALL register the round-robin winner (first set req at or after pointer ptr, wrapping) as grant/res_id.
  - len of winner != 0: next state STREAM.
  - len of winner == 0: next state RESULT with res_data forced to 0, and no MAC cycle is issued.
REQ-021 In STREAM, in_ready[grant] SHALL be 1; all other in_ready bits are 0 in every state.
REQ-022 In STREAM, a transfer SHALL occur when in_valid[grant] and in_ready[grant] are both high; on a transfer:
  - mac_en=1; mac_a/mac_b = the granted slices;
  - mac_clear=1 only on the first transfer of the job;
  - the element counter increments.
REQ-023 In STREAM without a transfer, the block SHALL drive mac_en=0 and mac_a=mac_b=0, stalling the MAC pipeline.
REQ-024 The transfer whose count equals len SHALL move the FSM to DRAIN.
REQ-025 DRAIN SHALL last exactly 2 cycles with mac_en=1, mac_clear=0, mac_a=mac_b=0, then move to RESULT.
REQ-026 In RESULT:
  - mac_en=0, so mac_acc holds;
  - res_valid=1;
  - res_data=mac_acc, or 0 for a len=0 job;
  - res_id, res_data and res_valid SHALL stay stable until res_ready.
REQ-027 On the RESULT handshake the block SHALL set ptr = res_id+1 modulo N and return to IDLE; a new arbitration occurs no earlier than the next cycle.
REQ-028 res_valid SHALL rise exactly 3 cycles after the clock edge accepting the last element, independent of res_ready.
REQ-029 Requests SHALL NOT be preempted: req changes of non-granted requesters during a job have no effect.
REQ-030 The granted requester's len and req are sampled only at grant; later changes are ignored until the job ends.
REQ-031 Element count SHALL saturate at no value; len=255 streams exactly 255 elements.
REQ-032 Simultaneous requests SHALL be served in round-robin order starting at ptr; no requester waits more than N-1 jobs.

Reset
REQ-033 While reset_n is low, the block SHALL asynchronously force:
  - state=IDLE, ptr=0, grant=0, counter=0;
  - mac_en=0, mac_clear=0, mac_a=0, mac_b=0;
  - in_ready=0, res_valid=0, res_id=0, res_data=0, busy=0.
REQ-034 Reset asserted mid-job SHALL abandon the job with no result.
REQ-035 After reset release, the first job's first transfer SHALL carry mac_clear=1, so stale accumulator contents are discarded.

Verification
REQ-036 Requester 0, len=3, a={1,2,3}, b={4,5,6}, in_valid held high -> mac_clear on element 1 only; res_valid 3 cycles after the last element; res_data=32, res_id=0.
REQ-037 Same job with in_valid low for 2 cycles between elements -> mac_en low in those cycles; res_data=32.
REQ-038 req=4'b1111, all len=1, a=b=i+1 -> results in order id 0,1,2,3 with data 1,4,9,16; then ptr=0.
REQ-039 Requester 2, len=0 -> res_valid with res_data=0, res_id=2; mac_en never asserted.
REQ-040 res_ready low for 5 cycles in RESULT -> res_valid, res_id and res_data stable; mac_en=0 throughout.
REQ-041 reset_n pulsed low during STREAM, then requester 1, len=2, a={-3,5}, b={7,2} -> all outputs zero during reset; after release res_data=-11, res_id=1.
